// File: rtl/nx_msg_if.sv
// Outbound node-message stream: registered data/valid from the loader, ready from the mesh edge.
interface nx_msg_if #(
    parameter int MSG_W = 52
) ();
    logic [MSG_W-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/nx_node_loader.sv
// Host-side node programmer: streams LOAD words, a PARAM control and loopback-mask slices to a node.
// Message layout (MSB first): row | column | command(2) | payload(RAM_ADDR_W+RAM_DATA_W).
module nx_node_loader #(
    parameter int INPUTS       = 32,
    parameter int RAM_ADDR_W   = 10,
    parameter int RAM_DATA_W   = 32,
    parameter int MASK_SLICE_W = 8,
    parameter int ROW_W        = 4,
    parameter int COL_W        = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ROW_W+COL_W-1:0]  i_req_node_id,
    input  logic [RAM_ADDR_W:0]     i_req_num_words,
    input  logic [RAM_ADDR_W-1:0]   i_req_src_base,
    input  logic [INPUTS-1:0]       i_req_loopback_mask,
    input  logic                    i_req_trace_en,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    output logic [RAM_ADDR_W-1:0]   o_src_rd_addr,
    output logic                    o_src_rd_en,
    input  logic [RAM_DATA_W-1:0]   i_src_rd_data,
    nx_msg_if.master                m_msg,
    output logic                    o_idle,
    output logic                    o_done
);
    localparam int ID_W    = ROW_W + COL_W;
    localparam int PAY_W   = RAM_ADDR_W + RAM_DATA_W;
    localparam int MSG_W   = ID_W + 2 + PAY_W;
    localparam int NSLICES = INPUTS / MASK_SLICE_W;
    localparam int SIDX_W  = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    localparam logic [1:0] CMD_LOAD    = 2'd1;
    localparam logic [1:0] CMD_CONTROL = 2'd2;
    localparam logic [1:0] SEL_PARAM   = 2'd0;
    localparam logic [1:0] SEL_LOOP    = 2'd1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_RD   = 3'd2;
    localparam logic [2:0] S_SEND_LOAD = 3'd3;
    localparam logic [2:0] S_SEND_PARAM= 3'd4;
    localparam logic [2:0] S_SEND_MASK = 3'd5;

    localparam logic [SIDX_W-1:0] LAST_SLICE = SIDX_W'(NSLICES - 1);

    logic [2:0]              r_state;
    logic [RAM_ADDR_W:0]     r_word_idx;
    logic [SIDX_W-1:0]       r_slice_idx;
    logic [ID_W-1:0]         r_node_id;
    logic [RAM_ADDR_W:0]     r_num_words;
    logic [RAM_ADDR_W-1:0]   r_src_base;
    logic [INPUTS-1:0]       r_mask;
    logic                    r_trace_en;
    logic [MSG_W-1:0]        r_msg_data;

    logic [RAM_ADDR_W:0]     w_word_nxt;
    logic [SIDX_W-1:0]       w_slice_nxt;
    logic                    w_accept;
    logic                    w_last_slice;

    function automatic logic [MSG_W-1:0] f_load_msg(
        input logic [ID_W-1:0]       id,
        input logic [RAM_ADDR_W-1:0] addr,
        input logic [RAM_DATA_W-1:0] data
    );
        return {id, CMD_LOAD, addr, data};
    endfunction

    // A full RAM's worth of words does not fit the num_instr field, so it saturates to all-ones.
    function automatic logic [MSG_W-1:0] f_param_msg(
        input logic [ID_W-1:0]     id,
        input logic [RAM_ADDR_W:0] num_words,
        input logic                trace_en
    );
        logic [PAY_W-1:0] p;
        p = '0;
        p[PAY_W-1 -: 2]        = SEL_PARAM;
        p[RAM_ADDR_W-1:0]      = num_words[RAM_ADDR_W] ? {RAM_ADDR_W{1'b1}} : num_words[RAM_ADDR_W-1:0];
        p[RAM_ADDR_W]          = trace_en;
        return {id, CMD_CONTROL, p};
    endfunction

    function automatic logic [MSG_W-1:0] f_mask_msg(
        input logic [ID_W-1:0]   id,
        input logic [INPUTS-1:0] mask,
        input logic [SIDX_W-1:0] idx
    );
        logic [PAY_W-1:0] p;
        p = '0;
        p[PAY_W-1 -: 2]             = SEL_LOOP;
        p[MASK_SLICE_W-1:0]         = mask[idx*MASK_SLICE_W +: MASK_SLICE_W];
        p[MASK_SLICE_W +: SIDX_W]   = idx;
        return {id, CMD_CONTROL, p};
    endfunction

    assign w_word_nxt   = r_word_idx + {{RAM_ADDR_W{1'b0}}, 1'b1};
    assign w_slice_nxt  = r_slice_idx + {{(SIDX_W-1){1'b0}}, 1'b1};
    assign w_accept     = m_msg.valid && m_msg.ready;
    assign w_last_slice = (r_slice_idx == LAST_SLICE);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_word_idx  <= '0;
            r_slice_idx <= '0;
            r_node_id   <= '0;
            r_num_words <= '0;
            r_src_base  <= '0;
            r_mask      <= '0;
            r_trace_en  <= 1'b0;
            r_msg_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_node_id   <= i_req_node_id;
                        r_num_words <= i_req_num_words;
                        r_src_base  <= i_req_src_base;
                        r_mask      <= i_req_loopback_mask;
                        r_trace_en  <= i_req_trace_en;
                        r_word_idx  <= '0;
                        r_slice_idx <= '0;
                        if (i_req_num_words == '0) begin
                            r_msg_data <= f_param_msg(i_req_node_id, i_req_num_words, i_req_trace_en);
                            r_state    <= S_SEND_PARAM;
                        end else begin
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: r_state <= S_WAIT_RD;
                // Source data arrives the cycle after the read strobe issued in FETCH.
                S_WAIT_RD: begin
                    r_msg_data <= f_load_msg(r_node_id, r_word_idx[RAM_ADDR_W-1:0], i_src_rd_data);
                    r_state    <= S_SEND_LOAD;
                end
                S_SEND_LOAD: begin
                    if (m_msg.ready) begin
                        r_word_idx <= w_word_nxt;
                        if (w_word_nxt == r_num_words) begin
                            r_msg_data <= f_param_msg(r_node_id, r_num_words, r_trace_en);
                            r_state    <= S_SEND_PARAM;
                        end else begin
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_SEND_PARAM: begin
                    if (m_msg.ready) begin
                        r_msg_data <= f_mask_msg(r_node_id, r_mask, '0);
                        r_state    <= S_SEND_MASK;
                    end
                end
                S_SEND_MASK: begin
                    if (m_msg.ready) begin
                        if (w_last_slice) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_slice_idx <= w_slice_nxt;
                            r_msg_data  <= f_mask_msg(r_node_id, r_mask, w_slice_nxt);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_msg.data    = r_msg_data;
    assign m_msg.valid   = (r_state == S_SEND_LOAD) || (r_state == S_SEND_PARAM) ||
                           (r_state == S_SEND_MASK);
    assign o_req_ready   = (r_state == S_IDLE);
    assign o_src_rd_en   = (r_state == S_FETCH);
    assign o_src_rd_addr = r_src_base + r_word_idx[RAM_ADDR_W-1:0];
    assign o_done        = (r_state == S_SEND_MASK) && w_accept && w_last_slice;
    // An incoming request already counts as busy in its accept cycle; reset overrides it.
    assign o_idle        = (r_state == S_IDLE) && !(i_rst && i_req_valid);

endmodule

// File: tb/tb_nx_node_loader.sv
// Scoreboard bench for nx_node_loader: randomized requests against a queue-based message model.
module tb_nx_node_loader;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int MW = 52;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    req_node_id;
    logic [AW:0]   req_num_words;
    logic [AW-1:0] req_src_base;
    logic [31:0]   req_mask;
    logic          req_trace;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          idle;
    logic          done;

    nx_msg_if #(.MSG_W(MW)) msg_if ();

    nx_node_loader dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_req_node_id       (req_node_id),
        .i_req_num_words     (req_num_words),
        .i_req_src_base      (req_src_base),
        .i_req_loopback_mask (req_mask),
        .i_req_trace_en      (req_trace),
        .i_req_valid         (req_valid),
        .o_req_ready         (req_ready),
        .o_src_rd_addr       (rd_addr),
        .o_src_rd_en         (rd_en),
        .i_src_rd_data       (rd_data),
        .m_msg               (msg_if),
        .o_idle              (idle),
        .o_done              (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src_mem [0:1023];
    always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

    logic [MW-1:0] exp_q[$];
    logic [AW-1:0] exp_rd_q[$];
    int checks = 0;
    int passed = 0;
    int msg_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    bit bp_en = 1'b0;
    bit rdy_hold = 1'b1;
    bit hold_pend = 1'b0;
    logic [MW-1:0] hold_data;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    endfunction

    // Reference message packing: row | col | cmd | payload; control payload starts with a 2-bit selector.
    function automatic logic [MW-1:0] m_load(logic [7:0] id, int addr, logic [31:0] d);
        logic [9:0] a;
        a = 10'(addr);
        return {id, 2'd1, a, d};
    endfunction

    function automatic logic [MW-1:0] m_param(logic [7:0] id, int nw, logic tr);
        logic [9:0] n;
        n = (nw >= 1024) ? 10'd1023 : 10'(nw);
        return {id, 2'd2, 2'd0, 29'd0, tr, n};
    endfunction

    function automatic logic [MW-1:0] m_mask(logic [7:0] id, logic [31:0] mask, int idx);
        logic [7:0] s;
        logic [1:0] i2;
        s  = 8'((mask >> (8 * idx)) & 32'hFF);
        i2 = 2'(idx);
        return {id, 2'd2, 2'd1, 30'd0, i2, s};
    endfunction

    function automatic void push_expected(logic [7:0] id, int nw, int base, logic [31:0] mask, logic tr);
        for (int i = 0; i < nw; i++) begin
            int a;
            a = (base + i) % 1024;
            exp_rd_q.push_back(AW'(a));
            exp_q.push_back(m_load(id, i, src_mem[a]));
        end
        exp_q.push_back(m_param(id, nw, tr));
        for (int i = 0; i < NS; i++) exp_q.push_back(m_mask(id, mask, i));
    endfunction

    always @(posedge clk) begin
        #2;
        msg_if.ready = bp_en ? 1'($urandom_range(0, 1)) : rdy_hold;
    end

    // Monitor: read strobes, message handshakes, hold stability and done pulses.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            hold_pend = 1'b0;
        end else begin
            if (rd_en) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(rd_addr), 64'hFFFF_FFFF);
                else check("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
                rd_cnt++;
            end
            if (hold_pend) begin
                check("hold_valid", 64'(msg_if.valid), 64'd1);
                check("hold_data", 64'(msg_if.data), 64'(hold_data));
            end
            if (msg_if.valid && msg_if.ready) begin
                msg_cnt++;
                hold_pend = 1'b0;
                if (exp_q.size() == 0) check("msg_extra", 64'(msg_if.data), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("msg", 64'(msg_if.data), 64'(exp_q.pop_front()));
            end else if (msg_if.valid) begin
                hold_pend = 1'b1;
                hold_data = msg_if.data;
            end else begin
                hold_pend = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("done_last", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    task automatic run_req(logic [3:0] row, logic [3:0] col, int nw, int base, logic [31:0] mask, logic tr);
        int m0, r0, d0, n;
        m0 = msg_cnt; r0 = rd_cnt; d0 = done_cnt;
        push_expected({row, col}, nw, base, mask, tr);
        @(posedge clk); #1;
        req_node_id   = {row, col};
        req_num_words = (AW+1)'(nw);
        req_src_base  = AW'(base);
        req_mask      = mask;
        req_trace     = tr;
        req_valid     = 1'b1;
        @(negedge clk);
        check("accept_ready", 64'(req_ready), 64'd1);
        check("accept_idle", 64'(idle), 64'd0);
        @(posedge clk); #1;
        req_valid     = 1'b0;
        req_node_id   = 8'($urandom);
        req_num_words = (AW+1)'($urandom);
        req_mask      = $urandom;
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("msg_count", 64'(msg_cnt - m0), 64'(nw + 1 + NS));
        check("rd_count", 64'(rd_cnt - r0), 64'(nw));
        check("exp_left", 64'(exp_q.size() + exp_rd_q.size()), 64'd0);
        check("idle_after", 64'(idle), 64'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!msg_if.valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("valid_seen", 64'(msg_if.valid), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) src_mem[i] = $urandom;
        rst = 1'b0;
        req_valid = 1'b1;
        req_node_id = 8'h5A;
        req_num_words = 11'd7;
        req_src_base = 10'h55;
        req_mask = 32'hFFFF_FFFF;
        req_trace = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(msg_if.valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", 64'(msg_if.data), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        req_valid = 1'b0;
        rst = 1'b1;

        run_req(4'd2, 4'd3, 4, 'h10, 32'hA5A5_0F0F, 1'b1);
        bp_en = 1'b1;
        run_req(4'd2, 4'd3, 4, 'h10, 32'hA5A5_0F0F, 1'b1);
        run_req(4'd7, 4'd1, 0, 'h33, 32'h1234_5678, 1'b0);
        run_req(4'd0, 4'd9, 3, 'h3FE, 32'hDEAD_BEEF, 1'b1);
        for (int k = 0; k < 6; k++) begin
            bp_en = 1'($urandom_range(0, 1));
            run_req(4'($urandom), 4'($urandom), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 1023)), $urandom, 1'($urandom));
        end
        bp_en = 1'b0;
        rdy_hold = 1'b1;
        run_req(4'd15, 4'd15, 1024, 'h200, 32'h0102_0408, 1'b0);

        // Abort during the second LOAD while ready is held low.
        begin
            int m0;
            rdy_hold = 1'b0;
            m0 = msg_cnt;
            push_expected(8'h45, 4, 'h40, 32'hCAFE_F00D, 1'b1);
            @(posedge clk); #1;
            req_node_id = 8'h45; req_num_words = 11'd4; req_src_base = 10'h40;
            req_mask = 32'hCAFE_F00D; req_trace = 1'b1; req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            wait_valid();
            rdy_hold = 1'b1;
            @(posedge clk); #1;
            rdy_hold = 1'b0;
            wait_valid();
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            check("abort_valid", 64'(msg_if.valid), 64'd0);
            check("abort_idle", 64'(idle), 64'd1);
            check("abort_msgs", 64'(msg_cnt - m0), 64'd1);
            exp_q.delete();
            exp_rd_q.delete();
            rst = 1'b1;
            rdy_hold = 1'b1;
        end
        bp_en = 1'b1;
        run_req(4'd4, 4'd5, 4, 'h40, 32'hCAFE_F00D, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time bound, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
